lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time and drives a word-aligned data bus.
// Define LSU_MISALIGN_EN to split misaligned accesses into two bus transactions.
module lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_ready_o,
  output logic                  lsu_rvalid_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i
);

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2} state_e;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    end
    return (f3[1:0] != 2'b11) && (f3 != 3'b110);
  endfunction

  // Accesses whose bytes spill past the end of the addressed word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  state_e                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    accept;
  logic                    reject;
  logic [1:0]              off;
  logic [4:0]              sh;
  logic [3:0]              base_be;
  logic [3:0]              be1;
  logic [31:0]             wd1;
  logic [31:0]             ld_raw;
  logic [31:0]             ld_ext;
  logic [ADDR_WIDTH-1:0]   addr1;

`ifdef LSU_MISALIGN_EN
  localparam logic [ADDR_WIDTH-3:0] WordInc = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  logic [31:0]             lo_q, lo_d;
  logic                    mis;
  logic [7:0]              be_wide;
  logic [63:0]             wd_wide;
  logic [63:0]             ld_cat;
  logic [ADDR_WIDTH-1:0]   addr2;

  assign reject = !is_legal(lsu_we_i, lsu_funct3_i);
`else
  assign reject = !is_legal(lsu_we_i, lsu_funct3_i) ||
                  is_misaligned(lsu_funct3_i, lsu_addr_i[1:0]);
`endif

  assign accept = (state_q == StIdle) && lsu_req_i;
  assign off    = addr_q[1:0];
  assign sh     = {off, 3'b000};
  assign addr1  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  assign mis     = is_misaligned(funct3_q, off);
  assign be_wide = {4'b0000, base_be} << off;
  assign wd_wide = {32'h0, wdata_q} << sh;
  assign be1     = be_wide[3:0];
  assign wd1     = wd_wide[31:0];
  assign addr2   = {addr_q[ADDR_WIDTH-1:2] + WordInc, 2'b00};
  // Second response supplies the upper bytes once the first word has been captured.
  assign ld_cat  = (state_q == StWait2) ? {data_rdata_i, lo_q} : {32'h0, data_rdata_i};
  assign ld_raw  = 32'(ld_cat >> sh);
`else
  assign be1     = base_be << off;
  assign wd1     = wdata_q << sh;
  assign ld_raw  = data_rdata_i >> sh;
`endif

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ld_ext = {{24{~funct3_q[2] & ld_raw[7]}}, ld_raw[7:0]};
      2'b01:   ld_ext = {{16{~funct3_q[2] & ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_EN
    lo_d     = lo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (lsu_req_i) begin
          if (reject) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = StReq1;
          end
        end
      end
      StReq1: begin
        if (data_gnt_i) state_d = StWait1;
      end
      StWait1: begin
        if (data_rvalid_i) begin
`ifdef LSU_MISALIGN_EN
          if (mis) begin
            lo_d    = data_rdata_i;
            state_d = StReq2;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = we_q ? 32'h0 : ld_ext;
            state_d  = StIdle;
          end
`else
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : ld_ext;
          state_d  = StIdle;
`endif
        end
      end
`ifdef LSU_MISALIGN_EN
      StReq2: begin
        if (data_gnt_i) state_d = StWait2;
      end
      StWait2: begin
        if (data_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : ld_ext;
          state_d  = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= lsu_we_i;
      funct3_q <= lsu_funct3_i;
      addr_q   <= lsu_addr_i;
      wdata_q  <= lsu_wdata_i;
    end
  end

`ifdef LSU_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 32'h0;
    end else begin
      lo_q <= lo_d;
    end
  end
`endif

  // Bus outputs are only non-zero while a request phase is active.
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_addr_o  = '0;
    data_wdata_o = 32'h0;
    if (state_q == StReq1) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be1;
      data_addr_o  = addr1;
      data_wdata_o = wd1;
    end
`ifdef LSU_MISALIGN_EN
    if (state_q == StReq2) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be_wide[7:4];
      data_addr_o  = addr2;
      data_wdata_o = wd_wide[63:32];
    end
`endif
  end

  assign lsu_ready_o  = rst_n && (state_q == StIdle);
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_err_o    = err_q;
  assign lsu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: bus handshakes are checked inline, completions
// against a scoreboard of expected results.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  lsu_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .data_req_o   (data_req_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] data, input logic err, input logic chk_data);
    exp_t e;
    e.data     = data;
    e.err      = err;
    e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    check("ready_before_req", {31'h0, lsu_ready_o}, 32'h1);
    lsu_req_i    = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wdata;
    tick();
    lsu_req_i    = 1'b0;
  endtask

  // One bus transaction with gnt withheld for gnt_delay cycles (stray rvalid_i meanwhile).
  task automatic bus_xfer(input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic exp_we, input logic [31:0] exp_wdata,
                          input int gnt_delay, input logic [31:0] rdata);
    for (int i = 0; i < 8 && data_req_o !== 1'b1; i++) tick();
    check("bus_req", {31'h0, data_req_o}, 32'h1);
    check("bus_addr", data_addr_o, exp_addr);
    check("bus_be", {28'h0, data_be_o}, {28'h0, exp_be});
    check("bus_we", {31'h0, data_we_o}, {31'h0, exp_we});
    if (exp_we) check("bus_wdata", data_wdata_o, exp_wdata);
    for (int i = 0; i < gnt_delay; i++) begin
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      tick();
      data_rvalid_i = 1'b0;
      check("stall_req", {31'h0, data_req_o}, 32'h1);
      check("stall_addr", data_addr_o, exp_addr);
      check("stall_be", {28'h0, data_be_o}, {28'h0, exp_be});
      if (exp_we) check("stall_wdata", data_wdata_o, exp_wdata);
    end
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    check("req_drop_after_gnt", {31'h0, data_req_o}, 32'h0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    tick();
    data_rvalid_i = 1'b0;
  endtask

  task automatic expect_err_resp(input string tag);
    check({tag, "_no_req"}, {31'h0, data_req_o}, 32'h0);
    check({tag, "_rvalid"}, {31'h0, lsu_rvalid_o}, 32'h1);
    check({tag, "_err"}, {31'h0, lsu_err_o}, 32'h1);
    tick();
    check({tag, "_pulse_end"}, {31'h0, lsu_rvalid_o}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && lsu_rvalid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_err", {31'h0, lsu_err_o}, {31'h0, e.err});
        if (e.chk_data) check("resp_rdata", lsu_rdata_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = 3'b000;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    tick();
    tick();
    check("rst_ready", {31'h0, lsu_ready_o}, 32'h0);
    check("rst_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
    check("rst_rdata", lsu_rdata_o, 32'h0);
    check("rst_data_req", {31'h0, data_req_o}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {31'h0, lsu_ready_o}, 32'h1);
    tick();

    // LW aligned, minimum latency
    sb_push(32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("lat_req_cycle1", {31'h0, data_req_o}, 32'h1);
    bus_xfer(32'h100, 4'b1111, 1'b0, 32'h0, 0, 32'hDEADBEEF);
    check("lat_rvalid_cycle3", {31'h0, lsu_rvalid_o}, 32'h1);
    tick();

    // LB / LBU at the top byte
    sb_push(32'hFFFFFF80, 1'b0, 1'b1);
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    bus_xfer(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h80000000);
    tick();
    sb_push(32'h00000080, 1'b0, 1'b1);
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    bus_xfer(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h80000000);
    tick();

    // SH with grant withheld for 4 cycles
    sb_push(32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
    bus_xfer(32'h200, 4'b1100, 1'b1, 32'hABCD0000, 4, 32'h0);
    tick();

    // LH / LHU
    sb_push(32'hFFFF8001, 1'b0, 1'b1);
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    bus_xfer(32'h100, 4'b1100, 1'b0, 32'h0, 1, 32'h80010000);
    tick();
    sb_push(32'h0000ABCD, 1'b0, 1'b1);
    issue(1'b0, 3'b101, 32'h101, 32'h0);
    bus_xfer(32'h100, 4'b0110, 1'b0, 32'h0, 0, 32'h00ABCD00);
    tick();

    // SB / SW
    sb_push(32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'b000, 32'h101, 32'h12345655);
    bus_xfer(32'h100, 4'b0010, 1'b1, 32'h34565500, 0, 32'h0);
    tick();
    sb_push(32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
    bus_xfer(32'h104, 4'b1111, 1'b1, 32'hCAFEF00D, 2, 32'h0);
    tick();

`ifdef LSU_MISALIGN_EN
    sb_push(32'hCCDDAABB, 1'b0, 1'b1);
    issue(1'b0, 3'b010, 32'h1FE, 32'h0);
    bus_xfer(32'h1FC, 4'b1100, 1'b0, 32'h0, 0, 32'hAABB1234);
    check("mis_no_early_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
    bus_xfer(32'h200, 4'b0011, 1'b0, 32'h0, 1, 32'h5678CCDD);
    check("mis_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
    tick();
    sb_push(32'h0, 1'b0, 1'b1);
    issue(1'b1, 3'b010, 32'h1FE, 32'h11223344);
    bus_xfer(32'h1FC, 4'b1100, 1'b1, 32'h33440000, 0, 32'h0);
    bus_xfer(32'h200, 4'b0011, 1'b1, 32'h00001122, 0, 32'h0);
    tick();
    sb_push(32'h00003412, 1'b0, 1'b1);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    bus_xfer(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 0, 32'h12000000);
    bus_xfer(32'h00000000, 4'b0001, 1'b0, 32'h0, 0, 32'h00000034);
    tick();
`else
    sb_push(32'h0, 1'b1, 1'b0);
    issue(1'b0, 3'b010, 32'h1FE, 32'h0);
    expect_err_resp("mis_lw");
    sb_push(32'h0, 1'b1, 1'b0);
    issue(1'b1, 3'b001, 32'h203, 32'h0);
    expect_err_resp("mis_sh");
`endif

    // Illegal encodings
    sb_push(32'h0, 1'b1, 1'b0);
    issue(1'b0, 3'b111, 32'h100, 32'h0);
    expect_err_resp("ill_load111");
    sb_push(32'h0, 1'b1, 1'b0);
    issue(1'b1, 3'b011, 32'h100, 32'h0);
    expect_err_resp("ill_store011");

    // Completed load leaves non-zero rdata before the reset test
    sb_push(32'h11223344, 1'b0, 1'b1);
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    bus_xfer(32'h300, 4'b1111, 1'b0, 32'h0, 0, 32'h11223344);
    tick();

    // Reset asserted while waiting for the response
    issue(1'b0, 3'b010, 32'h304, 32'h0);
    check("abort_req", {31'h0, data_req_o}, 32'h1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'h0, lsu_ready_o}, 32'h0);
    check("midrst_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
    check("midrst_err", {31'h0, lsu_err_o}, 32'h0);
    check("midrst_rdata", lsu_rdata_o, 32'h0);
    check("midrst_data_req", {31'h0, data_req_o}, 32'h0);
    check("midrst_data_we", {31'h0, data_we_o}, 32'h0);
    check("midrst_data_be", {28'h0, data_be_o}, 32'h0);
    check("midrst_data_addr", data_addr_o, 32'h0);
    check("midrst_data_wdata", data_wdata_o, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rerelease_ready", {31'h0, lsu_ready_o}, 32'h1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5A5A5A5A;
    tick();
    data_rvalid_i = 1'b0;
    check("stale_rvalid_ignored", {31'h0, lsu_rvalid_o}, 32'h0);
    check("stale_ready", {31'h0, lsu_ready_o}, 32'h1);
    tick();
    check("stale_rvalid_ignored2", {31'h0, lsu_rvalid_o}, 32'h0);
    check("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
